// File: rtl/ls_pkg.sv
// Load/store unit shared types.
// State encoding, op field layout and named opcodes.
package ls_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_RESP  = 2'b11
  } ls_state_t;

  localparam int OP_STORE = 3;
  localparam int OP_UNS   = 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] LB  = 4'b0000;
  localparam logic [3:0] LH  = 4'b0001;
  localparam logic [3:0] LW  = 4'b0010;
  localparam logic [3:0] LBU = 4'b0100;
  localparam logic [3:0] LHU = 4'b0101;
  localparam logic [3:0] SB  = 4'b1000;
  localparam logic [3:0] SH  = 4'b1001;
  localparam logic [3:0] SW  = 4'b1010;

  // Illegal size, unsigned store, misalignment or past the last word.
  function automatic logic op_err(
    input logic [3:0]  op,
    input logic [31:0] addr,
    input logic [31:0] last
  );
    logic e;
    e = 1'b0;
    if (op[1:0] == 2'b11) e = 1'b1;
    if (op[OP_STORE] && op[OP_UNS]) e = 1'b1;
    if (op[1:0] == SZ_HALF && addr[0]) e = 1'b1;
    if (op[1:0] == SZ_WORD && addr[1:0] != 2'b00) e = 1'b1;
    if (addr > last) e = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/ls_lane_align.sv
// Big-endian lane extract/extend for loads
// and lane merge for sub-word stores.
module ls_lane_align
  import ls_pkg::*;
(
  input  logic [31:0] i_rd_word,
  input  logic [31:0] i_buf,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_uns,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Load path: pick lane, then sign or zero extend.
  always_comb begin
    w_byte  = 8'h00;
    w_half  = 16'h0000;
    o_rdata = 32'h0;
    unique case (i_off)
      2'd0: w_byte = i_rd_word[31:24];
      2'd1: w_byte = i_rd_word[23:16];
      2'd2: w_byte = i_rd_word[15:8];
      2'd3: w_byte = i_rd_word[7:0];
    endcase
    w_half = i_off[1] ? i_rd_word[15:0] : i_rd_word[31:16];
    unique case (1'b1)
      (i_size == SZ_BYTE):
        o_rdata = i_uns ? {24'h0, w_byte}
                        : {{24{w_byte[7]}}, w_byte};
      (i_size == SZ_HALF):
        o_rdata = i_uns ? {16'h0, w_half}
                        : {{16{w_half[15]}}, w_half};
      default:
        o_rdata = i_rd_word;
    endcase
  end

  // Store path: overwrite the addressed lane of the buffered word.
  always_comb begin
    o_merged = i_buf;
    unique case (1'b1)
      (i_size == SZ_BYTE): begin
        unique case (i_off)
          2'd0: o_merged[31:24] = i_wdata[7:0];
          2'd1: o_merged[23:16] = i_wdata[7:0];
          2'd2: o_merged[15:8]  = i_wdata[7:0];
          2'd3: o_merged[7:0]   = i_wdata[7:0];
        endcase
      end
      (i_size == SZ_HALF): begin
        if (i_off[1]) o_merged[15:0]  = i_wdata[15:0];
        else          o_merged[31:16] = i_wdata[15:0];
      end
      default:
        o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a big-endian data memory.
// Single outstanding request, one-cycle response pulse.
module load_store_unit
  import ls_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] LAST = 32'(MEM_BYTES - 4);

  ls_state_t   r_state;
  logic [3:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_rdata;

  logic [31:0] w_ld_rdata;
  logic [31:0] w_merged;
  logic        w_err;

  assign w_err = op_err(req_op, req_addr, LAST);

  ls_lane_align u_align (
    .i_rd_word (mem_read_data),
    .i_buf     (r_buf),
    .i_wdata   (r_wdata),
    .i_off     (r_addr[1:0]),
    .i_size    (r_op[1:0]),
    .i_uns     (r_op[OP_UNS]),
    .o_rdata   (w_ld_rdata),
    .o_merged  (w_merged)
  );

  assign req_ready      = (r_state == S_IDLE);
  assign mem_address    = {r_addr[31:2], 2'b00};
  assign mem_write_data = w_merged;
  assign mem_read       = rst_n && (r_state == S_READ);
  assign mem_write      = rst_n && (r_state == S_WRITE);
  assign resp_valid     = r_resp_valid;
  assign resp_err       = r_resp_err;
  assign resp_rdata     = r_rdata;

  // Request sequencing and registered response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_op         <= 4'h0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_buf        <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rdata      <= 32'h0;
    end else begin
      r_resp_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (w_err) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_rdata      <= 32'h0;
            end else if (req_op[OP_STORE] &&
                         req_op[1:0] == SZ_WORD) begin
              r_state <= S_WRITE;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          r_buf <= mem_read_data;
          if (r_op[OP_STORE]) begin
            r_state <= S_WRITE;
          end else begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_rdata      <= w_ld_rdata;
          end
        end
        S_WRITE: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_rdata      <= 32'h0;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a
// byte-array big-endian memory model.
module tb_load_store_unit;
  import ls_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [0:1023];

  load_store_unit #(.MEM_BYTES(1024)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    mem_read_data = 32'h0;
    if (mem_address <= 32'd1020)
      mem_read_data = {mem[mem_address[9:0]],
                       mem[mem_address[9:0] + 10'd1],
                       mem[mem_address[9:0] + 10'd2],
                       mem[mem_address[9:0] + 10'd3]};
  end

  always @(posedge clk) begin
    if (mem_write && mem_address <= 32'd1020) begin
      mem[mem_address[9:0]]         <= mem_write_data[31:24];
      mem[mem_address[9:0] + 10'd1] <= mem_write_data[23:16];
      mem[mem_address[9:0] + 10'd2] <= mem_write_data[15:8];
      mem[mem_address[9:0] + 10'd3] <= mem_write_data[7:0];
    end
  end

  function automatic logic [31:0] mword(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  // One request; reports response data, latency and memory activity.
  task automatic do_req(
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rdata,
    output logic        err,
    output int          lat,
    output int          nrd,
    output int          nwr,
    output logic [31:0] wr_addr
  );
    bit got;
    rdata = 32'h0; err = 1'b0;
    lat = 0; nrd = 0; nwr = 0; wr_addr = 32'hFFFF_FFFF;
    got = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk);
      if (mem_read) nrd++;
      if (mem_write) begin
        nwr++;
        wr_addr = mem_address;
      end
      if (resp_valid) begin
        got = 1; lat = c;
        rdata = resp_rdata; err = resp_err;
      end
    end
    if (!got) lat = 99;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp_valid got %b want 0", resp_valid);
    end
    n_checks++;
    if (resp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp_err got %b want 0", resp_err);
    end
    n_checks++;
    if (resp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata got %h want 0", resp_rdata);
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got %b want 1", req_ready);
    end
    n_checks++;
    if ({mem_read, mem_write} !== 2'b00) begin
      n_fail++; $display("FAIL reset_mem_en got %b want 00",
                         {mem_read, mem_write});
    end
  endtask

  task automatic test_store_word();
    logic [31:0] rd, wa; logic er; int lat, nr, nw;
    do_req(SW, 32'd8, 32'h11223344, rd, er, lat, nr, nw, wa);
    n_checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
      n_fail++; $display("FAIL sw_resp lat %0d err %b rd %h want 2 0 0",
                         lat, er, rd);
    end
    n_checks++;
    if (nw !== 1 || nr !== 0 || wa !== 32'd8) begin
      n_fail++; $display("FAIL sw_mem nwr %0d nrd %0d addr %h want 1 0 8",
                         nw, nr, wa);
    end
    n_checks++;
    if (mword(8) !== 32'h11223344) begin
      n_fail++; $display("FAIL sw_bytes got %h want 11223344", mword(8));
    end
  endtask

  task automatic test_loads();
    logic [31:0] rd, wa; logic er; int lat, nr, nw;
    do_req(LB, 32'd9, 32'h0, rd, er, lat, nr, nw, wa);
    n_checks++;
    if (rd !== 32'h00000022 || lat !== 2 || nr !== 1 || nw !== 0) begin
      n_fail++; $display("FAIL lb9 rd %h lat %0d nrd %0d nwr %0d want 22 2 1 0",
                         rd, lat, nr, nw);
    end
    do_req(LW, 32'd8, 32'h0, rd, er, lat, nr, nw, wa);
    n_checks++;
    if (rd !== 32'h11223344 || lat !== 2 || nr !== 1 || er !== 1'b0) begin
      n_fail++; $display("FAIL lw8 rd %h lat %0d nrd %0d err %b want 11223344 2 1 0",
                         rd, lat, nr, er);
    end
  endtask

  task automatic test_sub_store();
    logic [31:0] rd, wa; logic er; int lat, nr, nw;
    do_req(SB, 32'd10, 32'h000000AB, rd, er, lat, nr, nw, wa);
    n_checks++;
    if (lat !== 3 || nr !== 1 || nw !== 1 || wa !== 32'd8 || er !== 1'b0) begin
      n_fail++; $display("FAIL sb_seq lat %0d nrd %0d nwr %0d addr %h want 3 1 1 8",
                         lat, nr, nw, wa);
    end
    n_checks++;
    if (mword(8) !== 32'h1122AB44) begin
      n_fail++; $display("FAIL sb_word got %h want 1122ab44", mword(8));
    end
    do_req(LH, 32'd10, 32'h0, rd, er, lat, nr, nw, wa);
    n_checks++;
    if (rd !== 32'hFFFFAB44) begin
      n_fail++; $display("FAIL lh10 got %h want ffffab44", rd);
    end
    do_req(LHU, 32'd10, 32'h0, rd, er, lat, nr, nw, wa);
    n_checks++;
    if (rd !== 32'h0000AB44) begin
      n_fail++; $display("FAIL lhu10 got %h want 0000ab44", rd);
    end
    do_req(LB, 32'd10, 32'h0, rd, er, lat, nr, nw, wa);
    n_checks++;
    if (rd !== 32'hFFFFFFAB) begin
      n_fail++; $display("FAIL lb10 got %h want ffffffab", rd);
    end
    do_req(LBU, 32'd8, 32'h0, rd, er, lat, nr, nw, wa);
    n_checks++;
    if (rd !== 32'h00000011) begin
      n_fail++; $display("FAIL lbu8 got %h want 00000011", rd);
    end
  endtask

  task automatic test_errors();
    logic [3:0]  ops [4] = '{LW, LH, SW, 4'b1100};
    logic [31:0] ads [4] = '{32'd6, 32'd5, 32'd1024, 32'd0};
    logic [31:0] rd, wa; logic er; int lat, nr, nw;
    for (int i = 0; i < 4; i++) begin
      do_req(ops[i], ads[i], 32'hDEADBEEF, rd, er, lat, nr, nw, wa);
      n_checks++;
      if (er !== 1'b1 || lat !== 1 || rd !== 32'h0 || nr !== 0 || nw !== 0) begin
        n_fail++;
        $display("FAIL err_case%0d err %b lat %0d rd %h nrd %0d nwr %0d want 1 1 0 0 0",
                 i, er, lat, rd, nr, nw);
      end
    end
    n_checks++;
    if (mword(8) !== 32'h1122AB44) begin
      n_fail++; $display("FAIL err_nowrite got %h want 1122ab44", mword(8));
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd, wa; logic er; int lat, nr, nw;
    int sw_wr, sw_rv;
    sw_wr = 0; sw_rv = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = SH;
    req_addr = 32'd8; req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_read got %b want 1", mem_read);
    end
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_write) sw_wr++;
      if (resp_valid) sw_rv++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_write) sw_wr++;
      if (resp_valid) sw_rv++;
    end
    n_checks++;
    if (sw_wr !== 0 || sw_rv !== 0) begin
      n_fail++; $display("FAIL rst_mid_abort nwr %0d nresp %0d want 0 0",
                         sw_wr, sw_rv);
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_ready got %b want 1", req_ready);
    end
    do_req(LW, 32'd8, 32'h0, rd, er, lat, nr, nw, wa);
    n_checks++;
    if (rd !== 32'h1122AB44 || er !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_old got %h err %b want 1122ab44 0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [3] = '{LW, LB, LHU};
    logic [31:0] ads [3] = '{32'd8, 32'd11, 32'd8};
    logic [31:0] exp [3] = '{32'h1122AB44, 32'h00000044, 32'h00001122};
    int idx, nresp, nbad;
    bit acc;
    idx = 0; nresp = 0; nbad = 0;
    for (int c = 0; c < 40 && nresp < 3; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        n_checks++;
        if (resp_rdata !== exp[nresp] || resp_err !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_resp%0d got %h err %b want %h 0",
                   nresp, resp_rdata, resp_err, exp[nresp]);
        end
        nresp++;
      end
      if (mem_read && mem_write) nbad++;
      req_valid = (idx < 3);
      if (idx < 3) begin
        req_op = ops[idx]; req_addr = ads[idx]; req_wdata = 32'h0;
      end
      acc = req_valid && req_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    req_valid = 1'b0;
    n_checks++;
    if (nresp !== 3 || idx !== 3) begin
      n_fail++; $display("FAIL b2b_count resp %0d acc %0d want 3 3", nresp, idx);
    end
    n_checks++;
    if (nbad !== 0) begin
      n_fail++; $display("FAIL b2b_rd_wr_overlap got %0d want 0", nbad);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0;
    req_op = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    test_reset();
    rst_n = 1'b1;
    test_store_word();
    test_loads();
    test_sub_store();
    test_errors();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
